// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Half adder and full adder (two half adders) used as the serial
// adder's one-bit datapath.
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  ha u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  ha u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, one bit per cycle, LSB first.
// Define SERIAL_ADD_OVF_EN to add the two's-complement overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic fa_s;
  logic fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic cmsb_q, cmsb_d;
`endif

  fa u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      cmsb_q   <= cmsb_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    cmsb_d   = cmsb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift form keeps WIDTH=1 legal (no [0:1] slice).
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_co;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          cmsb_d  = carry_q;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_sh_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = cmsb_q ^ cout_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         ovf;

  logic iv1 = 1'b0;
  logic ir1;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic c1 = 1'b0;
  logic ov1;
  logic or1 = 1'b1;
  logic s1;
  logic co1;
  logic bz1;
  logic of1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .a         (a1),
    .b         (b1),
    .cin       (c1),
    .out_valid (ov1),
    .out_ready (or1),
    .sum       (s1),
    .cout      (co1),
    .busy      (bz1)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (of1)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
  assign of1 = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   acc_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic ovp = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition and the signed-overflow rule.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic c, int acc);
    exp_t r;
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.s   = t[W-1:0];
    r.co  = t[W];
    r.ov  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    r.acc = acc;
    return r;
  endfunction

  // Accept detector: inputs are stable around the negedge before the edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sbq.push_back(model(a, b, cin, cyc + 1));
      acc_log.push_back(cyc + 1);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ovp <= 1'b0;
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!ovp) chk("latency", cyc - sbq[0].acc, W);
          if (out_ready) begin
            mon_e = sbq.pop_front();
            chk("sum", {24'd0, sum}, {24'd0, mon_e.s});
            chk("cout", {31'd0, cout}, {31'd0, mon_e.co});
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ov});
`endif
          end
        end
      end
      ovp <= out_valid && !out_ready;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic c);
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic w1op(logic x, logic y, logic c);
    int n = 0;
    logic [1:0] t;
    t = {1'b0, x} + {1'b0, y} + {1'b0, c};
    a1 = x;
    b1 = y;
    c1 = c;
    iv1 = 1'b1;
    @(negedge clk);
    while (!ir1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 iv1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w1_latency", n, 32'd1);
    chk("w1_sum", {31'd0, s1}, {31'd0, t[0]});
    chk("w1_cout", {31'd0, co1}, {31'd0, t[1]});
`ifdef SERIAL_ADD_OVF_EN
    chk("w1_ovf", {31'd0, of1}, {31'd0, (x == y) && (t[0] != x)});
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int stop;
    int seen;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(8'hFF, 8'h01, 1'b0);
    drain();
    send(8'h7F, 8'h01, 1'b0);
    drain();
    send(8'h80, 8'h80, 1'b0);
    drain();

    out_ready = 1'b0;
    send(8'h00, 8'h00, 1'b1);
    seen = 0;
    while (!out_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_sum", {24'd0, sum}, 32'h01);
      chk("hold_cout", {31'd0, cout}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    acc_log.delete();
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    a = 8'hA5;
    b = 8'h5A;
    cin = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    chk("b2b_accepts", acc_log.size(), 32'd2);
    if (acc_log.size() == 2)
      chk("b2b_gap", acc_log[1] - acc_log[0], W + 2);

    send(8'h3C, 8'h55, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 32'd0);
    @(posedge clk);
    #1;

    stop = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        stop = 1;
      end
      begin
        while (stop == 0) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      w1op(v[2], v[1], v[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/sum width in bits, legal range 1..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port sum  output  WIDTH  result a+b+cin, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry-out of the MSB.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL drive out_valid=1 only in DONE.
REQ-017 SHALL accept operands on a rising edge with in_valid&in_ready: latch a, b and cin into internal registers, clear the bit counter, and go to RUN.
REQ-018 In RUN, each cycle SHALL add exactly one bit, LSB first, using the single full-adder instance on the a_sh[0], b_sh[0] and carry registers.
REQ-019 In RUN, each cycle SHALL shift the sum bit into the MSB of sum_sh, load the adder carry into the carry register, and shift the a_sh and b_sh registers right by one.
REQ-020 SHALL leave RUN when count==WIDTH-1, so RUN lasts exactly WIDTH cycles, and go to DONE.
REQ-021 SHALL assert out_valid on the WIDTH-th rising edge after the accepting edge.
REQ-022 In DONE, SHALL hold sum, cout and out_valid stable until out_ready=1; that edge returns the FSM to IDLE.
REQ-023 SHALL ignore in_valid outside IDLE: no queuing and no overlap of operations.
REQ-024 When in_valid and out_ready are both high in DONE, SHALL accept no new operands that cycle; the next accept occurs no earlier than the cycle after the return to IDLE.
REQ-025 With WIDTH=1, SHALL spend one RUN cycle, then go to DONE.
REQ-026 SHALL size the counter as $clog2(WIDTH+1) bits and SHALL never wrap it within an operation.
REQ-027 SHALL keep sum and cout at their last result values while in IDLE.

Reset
REQ-028 While rst_n=0, SHALL asynchronously force state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, and clear all internal registers; with SERIAL_ADD_OVF_EN defined, SHALL also force ovf=0.
REQ-029 SHALL abort an operation in progress when rst_n asserts in RUN or DONE, and SHALL not return its result.
REQ-030 SHALL begin normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 With macro SERIAL_ADD_OVF_EN defined, SHALL add output port ovf (1 bit) equal to the carry into the MSB XOR cout, i.e. two's-complement overflow, valid with out_valid.
REQ-032 With SERIAL_ADD_OVF_EN defined, SHALL add one register capturing the carry into the MSB during the final RUN cycle.
REQ-033 Without SERIAL_ADD_OVF_EN, SHALL have no ovf port and no associated logic.

Structure
REQ-034 SHALL take the state enum typedef (IDLE, RUN, DONE) and a WIDTH_DEFAULT=8 constant from shared package serial_add_pkg.
REQ-035 SHALL instantiate the team's existing fa (full adder, built from two ha) exactly once as its only sub-module; all sequencing logic SHALL be local to serial_add_ctrl.

Verification
REQ-036 Bench SHALL cover: WIDTH=8, a=0xFF, b=0x01, cin=0 -> out_valid 8 cycles after accept, sum=0x00, cout=1.
REQ-037 Bench SHALL cover: a=0x7F, b=0x01, cin=0 with SERIAL_ADD_OVF_EN -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-038 Bench SHALL cover: a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0; then hold out_ready=0 for 5 cycles -> sum, cout and out_valid remain stable, in_ready=0.
REQ-039 Bench SHALL cover: rst_n pulsed low at RUN cycle 3 -> all outputs match the REQ-028 values immediately, with no out_valid afterward.
REQ-040 Bench SHALL cover: in_valid held high across a completion with out_ready=1 -> the second accept occurs the cycle after the return to IDLE, and both results are correct (e.g. 0x12+0x34=0x46, then 0xA5+0x5A+1=0x00 with cout=1).
REQ-041 Bench SHALL cover: WIDTH=1, a=1, b=1, cin=1 -> out_valid 1 cycle after accept, sum=1, cout=1.
